reaction_round_sequencer: RTL and testbench

Sequences a multi-round reaction-time session for the game datapath: per round, loads a random hold-off from the LFSR, waits, raises the "go" prompt, measures the btnL reaction in 100 Hz ticks, and accumulates last/best/sum statistics. It sits between the LFSR, the 100 Hz tick source and the button edge detector on one side, and the screen renderers (prompt, score, end screens) on the other. It replaces per-state slow-clock counters with single-clock, tick-enabled counting.

---
 rtl/reaction_round_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_reaction_round_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_round_sequencer.sv
// reaction_round_sequencer
//
// Runs a multi-round reaction-time session. For each round it:
//   1. loads a random hold-off from the LFSR,
//   2. waits out the hold-off,
//   3. raises the "go" prompt and counts the button reaction in 100 Hz ticks,
//   4. folds the result into the last/best/sum statistics.
// All counting happens on the system clock and is gated by the tick enable.
//
// Optional feature macro: FALSE_START_RETRY_EN
//   defined   - a press during the hold-off re-arms the same round.
//   undefined - a press during the hold-off scores a TIMEOUT penalty and
//               consumes the round.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous, active-low reset
//   start        session start pulse (honoured in IDLE/DONE only)
//   press        debounced button-edge pulse
//   tick         100 Hz single-cycle enable
//   rnd[8:0]     LFSR value, sampled only in ARM
//   busy         session in progress (not IDLE/DONE)
//   prompt       high while in GO
//   round_idx    current round, 0-based
//   last_time    reaction of the most recently finished round
//   best_time    minimum reaction this session (9'h1FF when none yet)
//   sum_time     sum of reactions this session
//   result_valid pulse when last/best/sum are updated
//   false_start  pulse on a press during the hold-off
//   timed_out    pulse on reaction timeout
//   done         pulse on entering DONE
module reaction_round_sequencer #(
    parameter int ROUNDS    = 4,
    parameter int MIN_WAIT  = 100,
    parameter int TIMEOUT   = 300,
    parameter int GAP_TICKS = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       press,
    input  logic       tick,
    input  logic [8:0] rnd,
    output logic       busy,
    output logic       prompt,
    output logic [2:0] round_idx,
    output logic [8:0] last_time,
    output logic [8:0] best_time,
    output logic [11:0] sum_time,
    output logic       result_valid,
    output logic       false_start,
    output logic       timed_out,
    output logic       done
);

    localparam logic [9:0]  MIN_W      = 10'(MIN_WAIT);
    localparam logic [8:0]  TIMEOUT_V  = 9'(TIMEOUT);
    localparam logic [15:0] GAP_LAST   = 16'(GAP_TICKS - 1);
    localparam logic [2:0]  LAST_ROUND = 3'(ROUNDS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_WAIT, S_GO, S_RESULT, S_GAP, S_DONE
    } state_t;

    state_t      state;
    logic [9:0]  wait_cnt;   // wide enough for rnd + MIN_WAIT
    logic [8:0]  react_cnt;
    logic [15:0] gap_cnt;

    // Small LFSR values are pushed up so the hold-off is never shorter
    // than MIN_WAIT ticks.
    function automatic logic [9:0] holdoff(input logic [8:0] r);
        if ({1'b0, r} < MIN_W)
            return {1'b0, r} + MIN_W;
        else
            return {1'b0, r};
    endfunction

    function automatic logic [8:0] min9(input logic [8:0] a, input logic [8:0] b);
        return (a < b) ? a : b;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            prompt       <= 1'b0;
            round_idx    <= 3'd0;
            last_time    <= 9'd0;
            best_time    <= 9'h1FF;
            sum_time     <= 12'd0;
            result_valid <= 1'b0;
            false_start  <= 1'b0;
            timed_out    <= 1'b0;
            done         <= 1'b0;
            wait_cnt     <= 10'd0;
            react_cnt    <= 9'd0;
            gap_cnt      <= 16'd0;
        end else begin
            result_valid <= 1'b0;
            false_start  <= 1'b0;
            timed_out    <= 1'b0;
            done         <= 1'b0;

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state     <= S_ARM;
                        busy      <= 1'b1;
                        round_idx <= 3'd0;
                        sum_time  <= 12'd0;
                        best_time <= 9'h1FF;
                        last_time <= 9'd0;
                    end
                end

                S_ARM: begin
                    wait_cnt  <= holdoff(rnd);
                    react_cnt <= 9'd0;
                    state     <= S_WAIT;
                end

                S_WAIT: begin
                    // A press wins even in the cycle the hold-off expires.
                    if (press) begin
                        false_start <= 1'b1;
`ifdef FALSE_START_RETRY_EN
                        state       <= S_ARM;
`else
                        last_time   <= TIMEOUT_V;
                        state       <= S_RESULT;
`endif
                    end else if (wait_cnt == 10'd0) begin
                        state  <= S_GO;
                        prompt <= 1'b1;
                    end else if (tick) begin
                        wait_cnt <= wait_cnt - 10'd1;
                    end
                end

                S_GO: begin
                    // Press beats both a same-cycle tick and the timeout.
                    if (press) begin
                        last_time <= react_cnt;
                        prompt    <= 1'b0;
                        state     <= S_RESULT;
                    end else if (react_cnt == TIMEOUT_V) begin
                        last_time <= TIMEOUT_V;
                        timed_out <= 1'b1;
                        prompt    <= 1'b0;
                        state     <= S_RESULT;
                    end else if (tick) begin
                        react_cnt <= react_cnt + 9'd1;
                    end
                end

                S_RESULT: begin
                    sum_time     <= sum_time + {3'b000, last_time};
                    best_time    <= min9(best_time, last_time);
                    result_valid <= 1'b1;
                    gap_cnt      <= 16'd0;
                    if (round_idx == LAST_ROUND) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= S_GAP;
                    end
                end

                S_GAP: begin
                    if (tick) begin
                        if (gap_cnt == GAP_LAST) begin
                            gap_cnt   <= 16'd0;
                            round_idx <= round_idx + 3'd1;
                            state     <= S_ARM;
                        end else begin
                            gap_cnt <= gap_cnt + 16'd1;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reaction_round_sequencer.sv
// Self-checking bench for reaction_round_sequencer (default parameters).
// A four-round session is driven from a vector table; timeout, false start,
// press/tick and press/timeout coincidences and mid-session reset are
// driven by hand-written sequences.
module tb_reaction_round_sequencer;

    localparam int TO  = 300;
    localparam int GAP = 50;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       press = 1'b0;
    logic       tick = 1'b0;
    logic [8:0] rnd = 9'd0;
    logic       busy, prompt, result_valid, false_start, timed_out, done;
    logic [2:0] round_idx;
    logic [8:0] last_time, best_time;
    logic [11:0] sum_time;

    int total = 0;
    int bad = 0;

    reaction_round_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .press(press), .tick(tick),
        .rnd(rnd), .busy(busy), .prompt(prompt), .round_idx(round_idx),
        .last_time(last_time), .best_time(best_time), .sum_time(sum_time),
        .result_valid(result_valid), .false_start(false_start),
        .timed_out(timed_out), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] rnd;
        int exp_wait;
        int react;
        int exp_last;
        int exp_best;
        int exp_sum;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // One clock: drive tick/press, let the edge happen, sample 1 time unit later.
    task automatic cyc(input logic t, input logic p);
        tick = t;
        press = p;
        @(posedge clk);
        #1;
        tick = 1'b0;
        press = 1'b0;
        start = 1'b0;
    endtask

    task automatic tick_pair();
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc(1'b0, 1'b0);
        chk("start_busy", busy, 1);
    endtask

    // Pass through ARM with value r, then scramble rnd to show it is not resampled.
    task automatic arm_only(input logic [8:0] r);
        rnd = r;
        cyc(1'b0, 1'b0);
        rnd = 9'h1AB;
    endtask

    task automatic arm_wait(input logic [8:0] r, input int exp_wait);
        int n;
        arm_only(r);
        n = 0;
        while (!prompt && n < 700) begin
            tick_pair();
            n++;
        end
        chk("wait_ticks", n, exp_wait);
    endtask

    task automatic gap(input int next_idx);
        repeat (GAP - 1) cyc(1'b1, 1'b0);
        chk("gap_hold_idx", round_idx, next_idx - 1);
        cyc(1'b1, 1'b0);
        chk("gap_next_idx", round_idx, next_idx);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{rnd: 9'd20,  exp_wait: 120, react: 50, exp_last: 50, exp_best: 50, exp_sum: 50};
        tbl[1] = '{rnd: 9'd150, exp_wait: 150, react: 30, exp_last: 30, exp_best: 30, exp_sum: 80};
        tbl[2] = '{rnd: 9'd99,  exp_wait: 199, react: 80, exp_last: 80, exp_best: 30, exp_sum: 160};
        tbl[3] = '{rnd: 9'd100, exp_wait: 100, react: 40, exp_last: 40, exp_best: 30, exp_sum: 200};

        // Reset state
        @(posedge clk); #1;
        cyc(1'b0, 1'b0);
        chk("rst_busy", busy, 0);
        chk("rst_prompt", prompt, 0);
        chk("rst_idx", round_idx, 0);
        chk("rst_last", last_time, 0);
        chk("rst_best", best_time, 9'h1FF);
        chk("rst_sum", sum_time, 0);
        chk("rst_pulses", {result_valid, false_start, timed_out, done}, 0);
        rst_n = 1'b1;
        cyc(1'b0, 1'b0);
        chk("idle_busy", busy, 0);

        // Session A: four scored rounds from the table
        do_start();
        for (int i = 0; i < 4; i++) begin
            arm_wait(tbl[i].rnd, tbl[i].exp_wait);
            repeat (tbl[i].react) tick_pair();
            cyc(1'b0, 1'b1);
            chk("press_prompt", prompt, 0);
            chk("rv_early", result_valid, 0);
            cyc(1'b0, 1'b0);
            chk("rv", result_valid, 1);
            chk("last", last_time, tbl[i].exp_last);
            chk("best", best_time, tbl[i].exp_best);
            chk("sum", sum_time, tbl[i].exp_sum);
            chk("idx", round_idx, i);
            if (i < 3) begin
                chk("done_mid", done, 0);
                chk("busy_mid", busy, 1);
                cyc(1'b0, 1'b0);
                chk("rv_one_cycle", result_valid, 0);
                gap(i + 1);
            end else begin
                chk("done_pulse", done, 1);
                chk("busy_done", busy, 0);
                cyc(1'b0, 1'b0);
                chk("done_single", done, 0);
                chk("busy_after", busy, 0);
                chk("best_held", best_time, 30);
                chk("sum_held", sum_time, 200);
            end
        end

        // Session B: timeout, false start, press+tick, reset during GO
        do_start();
        chk("restart_sum", sum_time, 0);
        chk("restart_best", best_time, 9'h1FF);
        arm_wait(9'd5, 105);
        begin
            int n;
            n = 0;
            while (!timed_out && n < 400) begin
                tick_pair();
                n++;
            end
            chk("timeout_ticks", n, TO);
        end
        chk("timeout_prompt", prompt, 0);
        cyc(1'b0, 1'b0);
        chk("to_rv", result_valid, 1);
        chk("to_pulse_single", timed_out, 0);
        chk("to_last", last_time, TO);
        chk("to_sum", sum_time, TO);
        chk("to_best", best_time, TO);
        gap(1);

        arm_only(9'd0);
        repeat (3) tick_pair();
        cyc(1'b0, 1'b1);
        chk("fs_pulse", false_start, 1);
        chk("fs_no_to", timed_out, 0);
        chk("fs_prompt", prompt, 0);
`ifdef FALSE_START_RETRY_EN
        chk("fs_idx", round_idx, 1);
        chk("fs_no_rv", result_valid, 0);
        arm_wait(9'd20, 120);
        repeat (12) tick_pair();
        cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b0);
        chk("pt_last", last_time, 12);
        chk("pt_best", best_time, 12);
        chk("pt_sum", sum_time, 312);
        gap(2);
`else
        cyc(1'b0, 1'b0);
        chk("fs_rv", result_valid, 1);
        chk("fs_last", last_time, TO);
        chk("fs_sum", sum_time, 2 * TO);
        gap(2);
        arm_wait(9'd20, 120);
        repeat (12) tick_pair();
        cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b0);
        chk("pt_last", last_time, 12);
        chk("pt_best", best_time, 12);
        chk("pt_sum", sum_time, 612);
        gap(3);
`endif
        arm_wait(9'd200, 200);
        repeat (5) tick_pair();
        rst_n = 1'b0;
        cyc(1'b0, 1'b0);
        rst_n = 1'b1;
        chk("mr_busy", busy, 0);
        chk("mr_prompt", prompt, 0);
        chk("mr_best", best_time, 9'h1FF);
        chk("mr_sum", sum_time, 0);
        chk("mr_idx", round_idx, 0);
        chk("mr_done", done, 0);
        begin
            int seen;
            seen = 0;
            repeat (3) begin
                cyc(1'b1, 1'b0);
                seen += int'(done) + int'(busy);
            end
            chk("mr_idle_quiet", seen, 0);
        end

        // Session C: press as hold-off expires, press at timeout
        do_start();
        arm_only(9'd100);
        repeat (99) tick_pair();
        cyc(1'b1, 1'b0);
        chk("zero_no_prompt_yet", prompt, 0);
        cyc(1'b0, 1'b1);
        chk("zero_fs", false_start, 1);
        chk("zero_prompt", prompt, 0);
`ifdef FALSE_START_RETRY_EN
        chk("zero_idx", round_idx, 0);
`else
        cyc(1'b0, 1'b0);
        chk("zero_last", last_time, TO);
        chk("zero_sum", sum_time, TO);
        gap(1);
`endif
        arm_wait(9'd150, 150);
        repeat (TO - 1) tick_pair();
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b1);
        chk("pto_no_to", timed_out, 0);
        chk("pto_prompt", prompt, 0);
        cyc(1'b0, 1'b0);
        chk("pto_rv", result_valid, 1);
        chk("pto_last", last_time, TO);
`ifdef FALSE_START_RETRY_EN
        chk("pto_sum", sum_time, TO);
`else
        chk("pto_sum", sum_time, 2 * TO);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
